// File: rtl/fir_lite_regs.sv
// fir_lite_regs: AXI4-Lite slave feeding a FIR controller register bus.
// Define FIR_LITE_RDBACK_EN for config/command/tap-count readback.
module fir_lite_regs #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [1:0]        config_valid,
  output logic [31:0]       input_config,
  output logic [31:0]       input_command,
  output logic [31:0]       config_tap,
  input  logic              cont_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } wr_st_e;

  wr_st_e      st_q, st_d;
  logic        aw_full_q, aw_full_d;
  logic [1:0]  aw_idx_q, aw_idx_d;
  logic        w_full_q, w_full_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  cfg_vld_q, cfg_vld_d;
  logic [31:0] cfg_q, cfg_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] tap_q, tap_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef FIR_LITE_RDBACK_EN
  logic [7:0]  tap_cnt_q, tap_cnt_d;
`endif

  logic        aw_hs, w_hs, ar_hs;
  logic        legal;
  logic [1:0]  rd_idx;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign unused_addr = ^{s_awaddr, s_araddr};

  assign s_awready = (st_q == IDLE) && !aw_full_q;
  assign s_wready  = (st_q == IDLE) && !w_full_q;
  assign s_arready = !rvalid_q;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  assign legal  = (aw_idx_q != 2'd0) && (w_strb_q == 4'hF);
  assign rd_idx = s_araddr[3:2];

  assign s_bvalid      = bvalid_q;
  assign s_bresp       = bresp_q;
  assign s_rvalid      = rvalid_q;
  assign s_rdata       = rdata_q;
  assign s_rresp       = 2'b00;
  assign config_valid  = cfg_vld_q;
  assign input_config  = cfg_q;
  assign input_command = cmd_q;
  assign config_tap    = tap_q;

  always_comb begin
    rd_mux = '0;
    unique case (rd_idx)
      2'd0: rd_mux = {31'b0, cont_ready};
`ifdef FIR_LITE_RDBACK_EN
      2'd1: rd_mux = cfg_q;
      2'd2: rd_mux = cmd_q;
      2'd3: rd_mux = {24'b0, tap_cnt_q};
`else
      default: rd_mux = '0;
`endif
    endcase
  end

  always_comb begin
    st_d      = st_q;
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    cfg_vld_d = 2'd0;
    cfg_d     = cfg_q;
    cmd_d     = cmd_q;
    tap_d     = tap_q;
`ifdef FIR_LITE_RDBACK_EN
    tap_cnt_d = tap_cnt_q;
`endif
    unique case (st_q)
      IDLE: begin
        if (aw_hs) begin
          aw_full_d = 1'b1;
          aw_idx_d  = s_awaddr[3:2];
        end
        if (w_hs) begin
          w_full_d = 1'b1;
          w_data_d = s_wdata;
          w_strb_d = s_wstrb;
        end
        // Issue as soon as both halves are in hand, even this cycle
        if (aw_full_d && w_full_d) st_d = ISSUE;
      end
      ISSUE: begin
        bvalid_d = 1'b1;
        bresp_d  = legal ? 2'b00 : 2'b10;
        st_d     = RESP;
        if (legal) begin
          cfg_vld_d = aw_idx_q;
          unique case (1'b1)
            aw_idx_q == 2'd1: cfg_d = w_data_q;
            aw_idx_q == 2'd2: cmd_d = w_data_q;
            default: begin
              tap_d = w_data_q;
`ifdef FIR_LITE_RDBACK_EN
              tap_cnt_d = tap_cnt_q + 8'd1;
`endif
            end
          endcase
        end
      end
      RESP: begin
        if (s_bready) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          st_d      = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      aw_full_q <= 1'b0;
      aw_idx_q  <= 2'd0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      cfg_vld_q <= 2'd0;
      cfg_q     <= '0;
      cmd_q     <= '0;
      tap_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
`ifdef FIR_LITE_RDBACK_EN
      tap_cnt_q <= '0;
`endif
    end else begin
      st_q      <= st_d;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      cfg_vld_q <= cfg_vld_d;
      cfg_q     <= cfg_d;
      cmd_q     <= cmd_d;
      tap_q     <= tap_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
`ifdef FIR_LITE_RDBACK_EN
      tap_cnt_q <= tap_cnt_d;
`endif
    end
  end

endmodule

// File: doc/fir_lite_regs.md
FIR_LITE_REGS -- requirements
Module: fir_lite_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, byte-address width of the AXI4-Lite slave (registers at 0x0, 0x4, 0x8, 0xC; bits [3:2] select).
REQ-002 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports s_awaddr input ADDR_W; s_awvalid input 1; s_awready output 1: write-address channel.
REQ-005 SHALL have ports s_wdata input 32; s_wstrb input 4; s_wvalid input 1; s_wready output 1: write-data channel.
REQ-006 SHALL have ports s_bresp output 2; s_bvalid output 1; s_bready input 1: write-response channel.
REQ-007 SHALL have ports s_araddr input ADDR_W; s_arvalid input 1; s_arready output 1: read-address channel.
REQ-008 SHALL have ports s_rdata output 32; s_rresp output 2; s_rvalid output 1; s_rready input 1: read-data channel.
REQ-009 SHALL have ports config_valid output 2 (1 config, 2 command, 3 tap, 0 idle); input_config, input_command, config_tap output 32 each: controller-side register bus.
REQ-010 SHALL have port cont_ready  input  1  controller status (1 = ready for configuration).

Function
REQ-011 SHALL capture AW and W independently into one-entry holders; s_awready = state IDLE and AW holder empty; s_wready = state IDLE and W holder empty.
REQ-012 SHALL run write FSM IDLE -> ISSUE (both holders full) -> RESP (next cycle) -> IDLE (s_bvalid && s_bready); holders cleared on leaving RESP.
REQ-013 SHALL, in ISSUE, for a legal write, register config_valid = address index and load the matching bus (1 -> input_config, 2 -> input_command, 3 -> config_tap) with wdata; config_valid visible the cycle after ISSUE, exactly one cycle.
REQ-014 SHALL treat as illegal a write to index 0 or with s_wstrb != 4'hF: no config_valid pulse, no bus update, s_bresp = 2'b10; legal writes return 2'b00.
REQ-015 SHALL hold s_bvalid from the cycle after ISSUE until s_bready; s_bresp stable while s_bvalid.
REQ-016 SHALL hold all three data buses at their last written value between pulses.
REQ-017 SHALL, with AW and W accepted in cycle 0, give config_valid in cycle 2 and s_bvalid in cycle 2 (s_bready high -> IDLE in cycle 3).
REQ-018 SHALL assert s_arready whenever s_rvalid is low and no read is pending; on handshake register s_rdata/s_rresp and raise s_rvalid next cycle, held until s_rready.
REQ-019 SHALL return on read index 0 {31'b0, cont_ready} sampled at the AR handshake; s_rresp always 2'b00.
REQ-020 SHALL process read and write channels independently; simultaneous read of 0x4 and write to 0x4 returns the pre-write value.

Reset
REQ-021 SHALL on rst_n low clear FSM to IDLE, empty holders, drive s_bvalid, s_rvalid, config_valid, s_bresp, s_rresp, s_rdata and all data buses to 0; s_awready, s_wready, s_arready become 1 the first cycle after release.
REQ-022 SHALL abandon any in-flight transaction on reset without issuing a pulse.

Configuration
REQ-023 SHALL, with FIR_LITE_RDBACK_EN defined, return on reads index 1 the last input_config, index 2 the last input_command, index 3 an 8-bit count (zero-extended) of legal tap writes since reset, wrapping 255 -> 0.
REQ-024 SHALL, without FIR_LITE_RDBACK_EN, return 0 for reads of indices 1-3 and omit the tap counter.

Verification
REQ-025 AW 0x4 + W 0x8000_0100 same cycle -> config_valid=1 one cycle, input_config=0x8000_0100, bresp 2'b00.
REQ-026 W 0x1 three cycles before AW 0x8 -> single config_valid=2 pulse after AW, input_command=0x1.
REQ-027 Write 0x0 or wstrb=4'h3 to 0xC -> bresp 2'b10, config_valid stays 0, config_tap unchanged.
REQ-028 cont_ready=1, read 0x0 with s_rready low 5 cycles -> s_rvalid held, s_rdata=0x1 stable.
REQ-029 With FIR_LITE_RDBACK_EN, 256 tap writes then read 0xC -> 0x0; without, read 0x4 -> 0x0.
REQ-030 rst_n low while s_bvalid pending -> s_bvalid and config_valid 0 next cycle, all ready signals 1 after release.
